// File: rtl/i2c_target_receiver.sv
// i2c_target_receiver
// ----------------------------------------------------------------------------
// I2C target (slave) write receiver. Accepts frames of the form
//   START, {DEV_ADDR, W}, register address, data byte(s) ..., STOP
// ACKs every byte of an addressed write on SDA. It presents each received
// register/data pair as a one-cycle o_valid pulse. Consecutive data bytes in
// one frame go to consecutive register addresses (auto-increment, 8'hFF wraps
// to 8'h00).
//
// Optional feature: define I2C_TARGET_GLITCH_FILTER_EN to put a 3-sample
// majority filter after each input synchronizer. The filter rejects 1-cycle
// pulses and adds 2 i_clk of latency. It needs i_clk >= 24x SCL; without it,
// i_clk >= 16x SCL is enough.
//
// Ports:
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_SCL            I2C clock from the master
//   io_SDA           I2C data, open-drain (driven 1'b0 or released to 1'bz)
//   o_register_addr  register address of the last completed write
//   o_data           data byte of the last completed write
//   o_valid          one-cycle pulse; o_register_addr/o_data change only here
//   o_busy           high while this target is addressed (address matched)
//   o_dbg_state      current FSM state, for debug/observation
//
// Handshake: o_valid is a pulse with no back-pressure. The pair on
// o_register_addr/o_data is valid in the o_valid cycle and holds until the
// next pulse.
// ----------------------------------------------------------------------------
module i2c_target_receiver #(
  parameter logic [6:0] DEV_ADDR = 7'h40
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_SCL,
  inout  wire        io_SDA,
  output logic [7:0] o_register_addr,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic [2:0] o_dbg_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DEV_ADDR  = 3'd1;
  localparam logic [2:0] S_ACK_DEV   = 3'd2;
  localparam logic [2:0] S_REG_ADDR  = 3'd3;
  localparam logic [2:0] S_ACK_REG   = 3'd4;
  localparam logic [2:0] S_DATA      = 3'd5;
  localparam logic [2:0] S_ACK_DATA  = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic scl_cur, sda_cur;
  logic scl_prev_q, sda_prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= i_SCL;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= io_SDA;
      sda_s2_q <= sda_s1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  // Majority of the current synced sample and the two before it. A single
  // odd sample never wins the vote, so a 1-cycle pulse is removed.
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;
  logic       scl_filt_d, sda_filt_d;

  always_comb begin
    scl_filt_d = (scl_s2_q & scl_hist_q[0]) | (scl_s2_q & scl_hist_q[1]) |
                 (scl_hist_q[0] & scl_hist_q[1]);
    sda_filt_d = (sda_s2_q & sda_hist_q[0]) | (sda_s2_q & sda_hist_q[1]) |
                 (sda_hist_q[0] & sda_hist_q[1]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_s2_q};
      sda_hist_q <= {sda_hist_q[0], sda_s2_q};
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_cur = scl_filt_q;
  assign sda_cur = sda_filt_q;
`else
  assign scl_cur = scl_s2_q;
  assign sda_cur = sda_s2_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_cur;
      sda_prev_q <= sda_cur;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  always_comb begin
    scl_rise  = scl_cur & ~scl_prev_q;
    scl_fall  = ~scl_cur & scl_prev_q;
    start_det = scl_cur & ~sda_cur & sda_prev_q;
    stop_det  = scl_cur & sda_cur & ~sda_prev_q;
  end

  // --------------------------------------------------------------------------
  // Protocol FSM
  // --------------------------------------------------------------------------
  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_sh_q, addr_sh_d;
  logic [7:0] data_sh_q, data_sh_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] byte_in;

  // The byte as it will be once the bit sampled on this rising edge is in.
  assign byte_in = {shift_q[6:0], sda_cur};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    reg_addr_d = reg_addr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sda_oe_d   = sda_oe_q;

    if (start_det || stop_det) begin
      // Bus conditions win over bit sampling; any partial byte is dropped.
      state_d   = start_det ? S_DEV_ADDR : S_IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        S_DEV_ADDR, S_REG_ADDR, S_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == S_DEV_ADDR) begin
                // Only a write to our address is ACKed; reads and foreign
                // addresses are left un-ACKed until the next START/STOP.
                if (byte_in[7:1] == DEV_ADDR && !byte_in[0]) begin
                  state_d = S_ACK_DEV;
                end else begin
                  state_d = S_WAIT_STOP;
                end
              end else if (state_q == S_REG_ADDR) begin
                addr_sh_d = byte_in;
                state_d   = S_ACK_REG;
              end else begin
                data_sh_d = byte_in;
                state_d   = S_ACK_DATA;
              end
            end
          end
        end
        S_ACK_DEV, S_ACK_REG, S_ACK_DATA: begin
          // First falling edge after bit 8 pulls SDA low for the ACK slot,
          // the following falling edge ends the slot and releases it.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == S_ACK_DEV) begin
                state_d = S_REG_ADDR;
              end else if (state_q == S_ACK_REG) begin
                state_d = S_DATA;
              end else begin
                reg_addr_d = addr_sh_q;
                data_d     = data_sh_q;
                valid_d    = 1'b1;
                addr_sh_d  = addr_sh_q + 8'd1;
                state_d    = S_DATA;
              end
            end
          end
        end
        S_IDLE, S_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      addr_sh_q  <= 8'd0;
      data_sh_q  <= 8'd0;
      reg_addr_q <= 8'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      reg_addr_q <= reg_addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  // Open-drain: only ever pull low or let go.
  assign io_SDA = sda_oe_q ? 1'b0 : 1'bz;

  assign o_register_addr = reg_addr_q;
  assign o_data          = data_q;
  assign o_valid         = valid_q;
  // Busy from the moment our address is matched until the frame ends.
  assign o_busy          = (state_q >= S_ACK_DEV) && (state_q <= S_ACK_DATA);
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_i2c_target_receiver.sv
// tb_i2c_target_receiver
// Directed-vector bench for i2c_target_receiver. A bit-banged I2C master
// drives SCL/SDA. A transaction-level model turns each written frame into
// the expected (register, data) pairs. One compare process checks every
// cycle's outputs against that model.
module tb_i2c_target_receiver;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int QTR = 8;   // 32 clk per SCL period
`else
  localparam int QTR = 4;   // 16 clk per SCL period
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic       scl;
  logic       m_sda_low;
  wire        sda_bus;
  logic [7:0] o_register_addr;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic [2:0] o_dbg_state;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2c_target_receiver #(.DEV_ADDR(7'h40)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_SCL           (scl),
    .io_SDA          (sda_bus),
    .o_register_addr (o_register_addr),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .o_busy          (o_busy),
    .o_dbg_state     (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [7:0]  held_addr;
  logic [7:0]  held_data;
  int          n_cmp;
  int          n_fail;
  int          pulse_cnt;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b expected=%b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of a write frame: first byte addresses us only if it is {0x40, W};
  // then byte 1 is the start register and each further byte lands on the
  // next register, wrapping at 8 bits.
  function automatic bit model_addressed(input logic [7:0] dev);
    return dev == 8'h80;
  endfunction

  task automatic model_frame(input logic [7:0] b[4], input int n);
    logic [7:0] reg_a;
    if (model_addressed(b[0]) && n >= 3) begin
      for (int i = 2; i < n; i++) begin
        reg_a = b[1] + 8'(i - 2);
        exp_q.push_back({reg_a, b[i]});
      end
    end
  endtask

  // Compare process: every cycle, either a pulse matching the next expected
  // pair, or outputs holding the last expected pair.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst_n) begin
      held_addr = 8'h00;
      held_data = 8'h00;
      chk1("valid_in_reset", o_valid, 1'b0);
    end else if (o_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        chk1("unexpected_valid", o_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk8("valid_addr", o_register_addr, e[15:8]);
        chk8("valid_data", o_data, e[7:0]);
        held_addr = e[15:8];
        held_data = e[7:0];
      end
    end else begin
      chk8("hold_addr", o_register_addr, held_addr);
      chk8("hold_data", o_data, held_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // START, also usable as repeated START from any SCL-low point.
  task automatic start_cond();
    m_sda_low = 1'b0;
    tick(QTR);
    scl = 1'b1;
    tick(QTR);
    m_sda_low = 1'b1;
    tick(QTR);
    scl = 1'b0;
    tick(QTR);
  endtask

  task automatic stop_cond();
    tick(QTR);
    m_sda_low = 1'b1;
    tick(QTR);
    scl = 1'b1;
    tick(QTR);
    m_sda_low = 1'b0;
    tick(2 * QTR);
  endtask

  // One data bit; optionally a 1-clk low glitch on SCL in the high phase.
  task automatic send_bit(input logic b, input bit glitch);
    tick(QTR);
    m_sda_low = ~b;
    tick(QTR);
    scl = 1'b1;
    if (glitch) begin
      tick(2);
      scl = 1'b0;
      tick(1);
      scl = 1'b1;
      tick(2 * QTR - 3);
    end else begin
      tick(2 * QTR);
    end
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit,
                           output logic ack, output logic busy_at_ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
    tick(QTR);
    m_sda_low = 1'b0;
    tick(QTR);
    scl = 1'b1;
    tick(QTR);
    ack = (sda_bus === 1'b0);
    busy_at_ack = o_busy;
    tick(QTR);
    scl = 1'b0;
  endtask

  task automatic run_write(input logic [7:0] b[4], input int n, input bit do_stop);
    logic ack, busy;
    bit   addressed;
    addressed = model_addressed(b[0]);
    model_frame(b, n);
    start_cond();
    for (int i = 0; i < n; i++) begin
      send_byte(b[i], -1, ack, busy);
      chk1($sformatf("ack_byte%0d_%h", i, b[i]), ack, addressed);
      if (i == 0) chk1("busy_after_addr", busy, addressed);
    end
    if (do_stop) stop_cond();
  endtask

  task automatic check_idle(input string tag);
    tick(4);
    chk1({tag, "_busy"}, o_busy, 1'b0);
    chk8({tag, "_state"}, {5'd0, o_dbg_state}, 8'd0);
    chk1({tag, "_sda_free"}, sda_bus, 1'b1);
    chk8({tag, "_drained"}, 8'(exp_q.size()), 8'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic ack, busy;
    int   p0;
    bit   seen;
    n_cmp = 0;
    n_fail = 0;
    pulse_cnt = 0;
    held_addr = 8'h00;
    held_data = 8'h00;
    rst_n = 1'b0;
    scl = 1'b1;
    m_sda_low = 1'b0;
    tick(3);
    chk8("rst_addr", o_register_addr, 8'h00);
    chk8("rst_data", o_data, 8'h00);
    chk1("rst_valid", o_valid, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk8("rst_state", {5'd0, o_dbg_state}, 8'd0);
    chk1("rst_sda", sda_bus, 1'b1);
    rst_n = 1'b1;
    tick(5);

    // 1: simple write 0x80, 0x06, 0xA5
    p0 = pulse_cnt;
    run_write('{8'h80, 8'h06, 8'hA5, 8'h00}, 3, 1'b1);
    check_idle("t1");
    chk8("t1_pulses", 8'(pulse_cnt - p0), 8'd1);
    chk8("t1_addr_lit", o_register_addr, 8'h06);
    chk8("t1_data_lit", o_data, 8'hA5);

    // 2: foreign address 0x41
    p0 = pulse_cnt;
    run_write('{8'h82, 8'h00, 8'h00, 8'h00}, 1, 1'b1);
    check_idle("t2");
    chk8("t2_pulses", 8'(pulse_cnt - p0), 8'd0);

    // 3: burst across the 0xFF -> 0x00 wrap
    p0 = pulse_cnt;
    run_write('{8'h80, 8'hFF, 8'h11, 8'h22}, 4, 1'b1);
    check_idle("t3");
    chk8("t3_pulses", 8'(pulse_cnt - p0), 8'd2);
    chk8("t3_addr_lit", o_register_addr, 8'h00);
    chk8("t3_data_lit", o_data, 8'h22);

    // 4: read request is NACKed, then repeated START with a normal write
    p0 = pulse_cnt;
    run_write('{8'h81, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
    run_write('{8'h80, 8'h10, 8'h3C, 8'h00}, 3, 1'b1);
    check_idle("t4");
    chk8("t4_pulses", 8'(pulse_cnt - p0), 8'd1);
    chk8("t4_addr_lit", o_register_addr, 8'h10);

    // 5: repeated START after 4 bits of 0xF0 discards the partial byte
    p0 = pulse_cnt;
    start_cond();
    send_byte(8'h80, -1, ack, busy);
    chk1("t5_ack_dev", ack, 1'b1);
    send_byte(8'h44, -1, ack, busy);
    chk1("t5_ack_reg", ack, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    run_write('{8'h80, 8'h20, 8'h55, 8'h00}, 3, 1'b1);
    check_idle("t5");
    chk8("t5_pulses", 8'(pulse_cnt - p0), 8'd1);
    chk8("t5_data_lit", o_data, 8'h55);

    // 6: 1-clk SCL low glitch during bit 4 of data byte 0x5A
    p0 = pulse_cnt;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    exp_q.push_back({8'h30, 8'h5A});
`else
    // Extra edge samples bit 4 twice: byte closes one clock early as 0x5D.
    exp_q.push_back({8'h30, 8'h5D});
`endif
    start_cond();
    send_byte(8'h80, -1, ack, busy);
    chk1("t6_ack_dev", ack, 1'b1);
    send_byte(8'h30, -1, ack, busy);
    chk1("t6_ack_reg", ack, 1'b1);
    send_byte(8'h5A, 4, ack, busy);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    chk1("t6_ack_data", ack, 1'b1);
`else
    chk1("t6_ack_data", ack, 1'b0);
`endif
    stop_cond();
    check_idle("t6");
    chk8("t6_pulses", 8'(pulse_cnt - p0), 8'd1);

    // 7: reset while SDA is held low in the register-address ACK slot
    p0 = pulse_cnt;
    start_cond();
    send_byte(8'h80, -1, ack, busy);
    chk1("t7_ack_dev", ack, 1'b1);
    for (int i = 7; i >= 0; i--) send_bit(i == 4, 1'b0);   // 0x10
    m_sda_low = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 * QTR && !seen; i++) begin
      tick(1);
      if (sda_bus === 1'b0) seen = 1'b1;
    end
    chk1("t7_ack_driven", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t7_sda_released", sda_bus, 1'b1);
    chk8("t7_state", {5'd0, o_dbg_state}, 8'd0);
    chk8("t7_addr", o_register_addr, 8'h00);
    chk8("t7_data", o_data, 8'h00);
    chk1("t7_busy", o_busy, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    stop_cond();
    check_idle("t7");
    chk8("t7_pulses", 8'(pulse_cnt - p0), 8'd0);

    // after reset a fresh frame works normally
    run_write('{8'h80, 8'h7E, 8'hC3, 8'h00}, 3, 1'b1);
    check_idle("t8");
    chk8("t8_data_lit", o_data, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
